// File: rtl/ap_pkg.sv
// ap_pkg: shared types and truth tables for the bit-serial associative processor.
// Pass index p encodes the searched key: a = p[0], b = p[1], carry-in = p[2].
package ap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } ap_state_e;

    localparam logic [2:0] CMD_OR  = 3'd0;
    localparam logic [2:0] CMD_AND = 3'd1;
    localparam logic [2:0] CMD_XOR = 3'd2;
    localparam logic [2:0] CMD_ADD = 3'd3;

    // Result bit per pass index (bit p of the constant is the result for key p).
    localparam logic [7:0] LUT_OR_RES   = 8'h0E;
    localparam logic [7:0] LUT_AND_RES  = 8'h08;
    localparam logic [7:0] LUT_XOR_RES  = 8'h06;
    localparam logic [7:0] LUT_ADD_SUM  = 8'h96;
    localparam logic [7:0] LUT_ADD_COUT = 8'hE8;

    // Index of the last pass of a bit: 4 passes for logic ops, 8 for ADD.
    function automatic logic [2:0] lut_last(input logic [2:0] c);
        return (c == CMD_ADD) ? 3'd7 : 3'd3;
    endfunction

    function automatic logic lut_res(input logic [2:0] c, input logic [2:0] p);
        logic r;
        case (c)
            CMD_OR:  r = LUT_OR_RES[p];
            CMD_AND: r = LUT_AND_RES[p];
            CMD_XOR: r = LUT_XOR_RES[p];
            CMD_ADD: r = LUT_ADD_SUM[p];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic lut_cout(input logic [2:0] p);
        return LUT_ADD_COUT[p];
    endfunction

endpackage

// File: rtl/ap_cam_col.sv
// ap_cam_col: one CAM column. Host word read/write, one-hot masked bit compare
// across every row, and a tag-gated single-bit write into every row in parallel.
module ap_cam_col #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = $clog2(CELL_QUANT)
) (
    input  logic                  clka,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [WORD_SIZE-1:0]  wdata,
    output logic [WORD_SIZE-1:0]  rd_data,
    input  logic [WORD_SIZE-1:0]  bit_mask,
    input  logic                  cmp_en,
    input  logic                  key,
    output logic [CELL_QUANT-1:0] match,
    input  logic [CELL_QUANT-1:0] bw_en,
    input  logic                  bw_val
);

    logic [WORD_SIZE-1:0] mem [CELL_QUANT];
    logic                 addr_ok;

    assign addr_ok = ({1'b0, addr} < (ADDR_W+1)'(CELL_QUANT));
    assign rd_data = addr_ok ? mem[addr] : '0;

    // Masked compare of the selected bit against the key; disabled columns match everywhere
    always_comb begin
        match = '1;
        for (int r = 0; r < CELL_QUANT; r++) begin
            if (cmp_en)
                match[r] = ((|(mem[r] & bit_mask)) == key);
        end
    end

    // Host word write and tag-gated single-bit write (never active in the same cycle)
    always_ff @(posedge clka) begin
        if (host_we && addr_ok)
            mem[addr] <= wdata;
        for (int r = 0; r < CELL_QUANT; r++) begin
            if (bw_en[r])
                mem[r] <= bw_val ? (mem[r] | bit_mask) : (mem[r] & ~bit_mask);
        end
    end

endmodule

// File: rtl/ap_bitserial_alu.sv
// ap_bitserial_alu: associative-processor tile computing C[r] = op(A[r], B[r])
// bit-serially on all rows at once, with host load/readback and a sticky irq.
// Optional build macro AP_ADD_EN enables cmd=3 (ADD) with per-row carry storage.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | host port active, waiting for start
// ST_COMPARE | tag rows whose current bits match the pass key
// ST_WRITE   | write LUT result into C for tagged rows, advance pass/bit
// ST_DONE    | raise irq, drop busy, return to idle
module ap_bitserial_alu
    import ap_pkg::*;
#(
    parameter  int WORD_SIZE  = 8,
    parameter  int CELL_QUANT = 512,
    localparam int ADDR_W     = $clog2(CELL_QUANT)
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [1:0]           sel_col,
    input  logic                 write_en,
    input  logic                 read_en,
    output logic [WORD_SIZE-1:0] data_out,
    input  logic                 start,
    input  logic [2:0]           cmd,
    output logic                 busy,
    output logic                 ap_state_irq,
    input  logic                 irq_clr
);

    localparam int BCW = $clog2(WORD_SIZE + 1);

    ap_state_e             state;
    logic [2:0]            op;
    logic [BCW-1:0]        bit_cnt;
    logic [2:0]            pass_cnt;
    logic [CELL_QUANT-1:0] tag;
    logic [CELL_QUANT-1:0] match_a, match_b, match_c;
    logic [CELL_QUANT-1:0] carry_term;
    logic [CELL_QUANT-1:0] bw_en_c;
    logic [WORD_SIZE-1:0]  bit_mask;
    logic [WORD_SIZE-1:0]  rd_a, rd_b, rd_c, rd_word;
    logic                  host_ok, we_a, we_b, we_c, bw_val, cmd_ok;

    assign host_ok  = (state == ST_IDLE);
    assign we_a     = host_ok & write_en & (sel_col == 2'd0);
    assign we_b     = host_ok & write_en & (sel_col == 2'd1);
    assign we_c     = host_ok & write_en & (sel_col == 2'd2);
    assign bit_mask = WORD_SIZE'(1) << bit_cnt;
    assign bw_val   = lut_res(op, pass_cnt);
    assign bw_en_c  = (state == ST_WRITE) ? tag : '0;

`ifdef AP_ADD_EN
    assign cmd_ok = (cmd == CMD_OR) || (cmd == CMD_AND) || (cmd == CMD_XOR) || (cmd == CMD_ADD);

    logic [CELL_QUANT-1:0] carry, carry_nxt, carry_wr;
    logic                  add_op;

    assign add_op     = (op == CMD_ADD);
    assign carry_term = add_op ? (pass_cnt[2] ? carry : ~carry) : '1;
    assign carry_wr   = lut_cout(pass_cnt) ? (carry_nxt | tag) : (carry_nxt & ~tag);

    // Carry bookkeeping: carry_nxt collects this bit's carry-outs, carry takes them after the last pass
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            carry     <= '0;
            carry_nxt <= '0;
        end else if (state == ST_IDLE && start) begin
            carry     <= '0;
            carry_nxt <= '0;
        end else if (state == ST_WRITE && add_op) begin
            carry_nxt <= carry_wr;
            if (pass_cnt == 3'd7)
                carry <= carry_wr;
        end
    end
`else
    assign cmd_ok     = (cmd == CMD_OR) || (cmd == CMD_AND) || (cmd == CMD_XOR);
    assign carry_term = '1;
`endif

    // Host read data source
    always_comb begin
        case (sel_col)
            2'd0:    rd_word = rd_a;
            2'd1:    rd_word = rd_b;
            2'd2:    rd_word = rd_c;
            default: rd_word = '0;
        endcase
    end

    // Latch the tag vector at the end of COMPARE for use in WRITE
    always_ff @(posedge CLK100MHZ) begin
        if (state == ST_COMPARE)
            tag <= match_a & match_b & match_c & carry_term;
    end

    // Control FSM with registered busy/irq/data_out
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state        <= ST_IDLE;
            op           <= CMD_OR;
            bit_cnt      <= '0;
            pass_cnt     <= '0;
            busy         <= 1'b0;
            ap_state_irq <= 1'b0;
            data_out     <= '0;
        end else begin
            if (irq_clr)
                ap_state_irq <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_en)
                        data_out <= rd_word;
                    if (start) begin
                        op       <= cmd;
                        bit_cnt  <= '0;
                        pass_cnt <= '0;
                        if (cmd_ok) begin
                            state <= ST_COMPARE;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_COMPARE: state <= ST_WRITE;
                ST_WRITE: begin
                    if (pass_cnt == lut_last(op)) begin
                        pass_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        state    <= (bit_cnt == BCW'(WORD_SIZE - 1)) ? ST_DONE : ST_COMPARE;
                    end else begin
                        pass_cnt <= pass_cnt + 3'd1;
                        state    <= ST_COMPARE;
                    end
                end
                ST_DONE: begin
                    ap_state_irq <= 1'b1;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ap_cam_col #(.WORD_SIZE(WORD_SIZE), .CELL_QUANT(CELL_QUANT), .ADDR_W(ADDR_W)) u_col_a (
        .clka     (CLK100MHZ),
        .host_we  (we_a),
        .addr     (addr_in),
        .wdata    (data_in),
        .rd_data  (rd_a),
        .bit_mask (bit_mask),
        .cmp_en   (1'b1),
        .key      (pass_cnt[0]),
        .match    (match_a),
        .bw_en    ('0),
        .bw_val   (1'b0)
    );

    ap_cam_col #(.WORD_SIZE(WORD_SIZE), .CELL_QUANT(CELL_QUANT), .ADDR_W(ADDR_W)) u_col_b (
        .clka     (CLK100MHZ),
        .host_we  (we_b),
        .addr     (addr_in),
        .wdata    (data_in),
        .rd_data  (rd_b),
        .bit_mask (bit_mask),
        .cmp_en   (1'b1),
        .key      (pass_cnt[1]),
        .match    (match_b),
        .bw_en    ('0),
        .bw_val   (1'b0)
    );

    ap_cam_col #(.WORD_SIZE(WORD_SIZE), .CELL_QUANT(CELL_QUANT), .ADDR_W(ADDR_W)) u_col_c (
        .clka     (CLK100MHZ),
        .host_we  (we_c),
        .addr     (addr_in),
        .wdata    (data_in),
        .rd_data  (rd_c),
        .bit_mask (bit_mask),
        .cmp_en   (1'b0),
        .key      (1'b0),
        .match    (match_c),
        .bw_en    (bw_en_c),
        .bw_val   (bw_val)
    );

endmodule

// File: tb/tb_ap_bitserial_alu.sv
// tb_ap_bitserial_alu: directed checks of host port, OR/AND/XOR/ADD results,
// latency, irq handling, busy-time lockout and mid-operation reset.
module tb_ap_bitserial_alu;

    localparam int WS = 8;
    localparam int CQ = 12;
    localparam int AW = $clog2(CQ);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr_in = '0;
    logic [WS-1:0] data_in = '0;
    logic [1:0]    sel_col = 2'd3;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [WS-1:0] data_out;
    logic          start = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic          busy;
    logic          ap_state_irq;
    logic          irq_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [WS-1:0] rd;

    ap_bitserial_alu #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
        .CLK100MHZ    (clk),
        .rst          (rst),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .sel_col      (sel_col),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_out     (data_out),
        .start        (start),
        .cmd          (cmd),
        .busy         (busy),
        .ap_state_irq (ap_state_irq),
        .irq_clr      (irq_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] col, input logic [AW-1:0] a, input logic [WS-1:0] d);
        sel_col = col; addr_in = a; data_in = d; write_en = 1'b1;
        tick();
        write_en = 1'b0; sel_col = 2'd3;
    endtask

    task automatic host_read(input logic [1:0] col, input logic [AW-1:0] a, output logic [WS-1:0] d);
        sel_col = col; addr_in = a; read_en = 1'b1;
        tick();
        read_en = 1'b0; sel_col = 2'd3;
        d = data_out;
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    // Launch cmd, count edges (start-sampling edge = 1) until irq, check busy level while running.
    task automatic run_op(input logic [2:0] c, input int exp_lat, input logic exp_busy,
                          input logic inject, input string tag);
        int n;
        logic busy_bad;
        logic [WS-1:0] held;
        if (ap_state_irq) clear_irq();
        held = data_out;
        cmd = c; start = 1'b1;
        tick();
        start = 1'b0; n = 1; busy_bad = 1'b0;
        while (!ap_state_irq && n < 400) begin
            if (busy !== exp_busy) busy_bad = 1'b1;
            if (inject && n == 10) begin
                sel_col = 2'd0; addr_in = '0; data_in = 8'h00;
                write_en = 1'b1; read_en = 1'b1; start = 1'b1; cmd = 3'd1;
            end
            tick();
            n++;
            if (inject && n == 11) begin
                write_en = 1'b0; read_en = 1'b0; start = 1'b0; sel_col = 2'd3;
                check({tag, "_dout_hold"}, data_out, held);
            end
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_run"}, busy_bad, 1'b0);
        check({tag, "_busy_done"}, busy, 1'b0);
    endtask

    initial begin
        // reset
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_irq", ap_state_irq, 1'b0);
        check("rst_dout", data_out, 8'h00);

        // operand load
        host_write(2'd0, 4'd0, 8'hA5); host_write(2'd1, 4'd0, 8'h3C);
        host_write(2'd0, 4'd1, 8'h0F); host_write(2'd1, 4'd1, 8'hF0);
        host_write(2'd0, 4'd2, 8'h12); host_write(2'd1, 4'd2, 8'h34);
        host_write(2'd0, 4'd5, 8'hFF); host_write(2'd1, 4'd5, 8'h01);
        host_write(2'd0, 4'd6, 8'h7F); host_write(2'd1, 4'd6, 8'h7F);
        host_write(2'd0, 4'd3, 8'h0F);

        // host port corner cases
        host_read(2'd0, 4'd0, rd);  check("rd_a0", rd, 8'hA5);
        host_write(2'd0, 4'd13, 8'h55);
        host_read(2'd0, 4'd13, rd); check("rd_oob", rd, 8'h00);
        host_read(2'd1, 4'd0, rd);  check("rd_b0", rd, 8'h3C);
        host_read(2'd3, 4'd0, rd);  check("rd_sel3", rd, 8'h00);
        host_write(2'd3, 4'd0, 8'h11);
        host_read(2'd0, 4'd0, rd);  check("wr_sel3_ignored", rd, 8'hA5);
        sel_col = 2'd0; addr_in = 4'd3; data_in = 8'h33; write_en = 1'b1; read_en = 1'b1;
        tick();
        write_en = 1'b0; read_en = 1'b0; sel_col = 2'd3;
        check("rdw_old", data_out, 8'h0F);
        host_read(2'd0, 4'd3, rd);  check("rdw_new", rd, 8'h33);

        // OR
        run_op(3'd0, 66, 1'b1, 1'b0, "or");
        host_read(2'd2, 4'd0, rd); check("or_c0", rd, 8'hBD);
        host_read(2'd2, 4'd1, rd); check("or_c1", rd, 8'hFF);
        host_read(2'd2, 4'd2, rd); check("or_c2", rd, 8'h36);
        host_read(2'd2, 4'd6, rd); check("or_c6", rd, 8'h7F);

        // AND
        run_op(3'd1, 66, 1'b1, 1'b0, "and");
        host_read(2'd2, 4'd0, rd); check("and_c0", rd, 8'h24);
        host_read(2'd2, 4'd1, rd); check("and_c1", rd, 8'h00);
        host_read(2'd2, 4'd2, rd); check("and_c2", rd, 8'h10);

        // XOR
        run_op(3'd2, 66, 1'b1, 1'b0, "xor");
        host_read(2'd2, 4'd0, rd); check("xor_c0", rd, 8'h99);
        host_read(2'd2, 4'd1, rd); check("xor_c1", rd, 8'hFF);
        host_read(2'd2, 4'd2, rd); check("xor_c2", rd, 8'h26);
        host_read(2'd2, 4'd5, rd); check("xor_c5", rd, 8'hFE);

        // ADD (or reserved when the adder is not built)
`ifdef AP_ADD_EN
        run_op(3'd3, 130, 1'b1, 1'b0, "add");
        host_read(2'd2, 4'd5, rd); check("add_c5", rd, 8'h00);
        host_read(2'd2, 4'd6, rd); check("add_c6", rd, 8'hFE);
        host_read(2'd2, 4'd0, rd); check("add_c0", rd, 8'hE1);
        host_read(2'd2, 4'd2, rd); check("add_c2", rd, 8'h46);
`else
        run_op(3'd3, 2, 1'b0, 1'b0, "add_off");
        host_read(2'd2, 4'd5, rd); check("add_off_c5", rd, 8'hFE);
        host_read(2'd2, 4'd6, rd); check("add_off_c6", rd, 8'h00);
        host_read(2'd2, 4'd0, rd); check("add_off_c0", rd, 8'h99);
        host_read(2'd2, 4'd2, rd); check("add_off_c2", rd, 8'h26);
`endif
        host_read(2'd2, 4'd1, rd);
        check("prev_c1", rd, `ifdef AP_ADD_EN 8'hFF `else 8'hFF `endif);

        // start does not clear a pending irq
        cmd = 3'd6; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_keeps_irq", ap_state_irq, 1'b1);
        tick();

        // reserved cmd
        run_op(3'd6, 2, 1'b0, 1'b0, "rsv");
        check("rsv_irq", ap_state_irq, 1'b1);
        host_read(2'd2, 4'd5, rd);
`ifdef AP_ADD_EN
        check("rsv_c5", rd, 8'h00);
`else
        check("rsv_c5", rd, 8'hFE);
`endif
        clear_irq();
        check("irq_clr", ap_state_irq, 1'b0);

        // irq_clr coincident with DONE: set wins
        cmd = 3'd7; start = 1'b1;
        tick();
        start = 1'b0; irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("clr_vs_done", ap_state_irq, 1'b1);

        // host write and second start during busy are ignored
        host_read(2'd1, 4'd1, rd); check("rd_b1", rd, 8'hF0);
        run_op(3'd0, 66, 1'b1, 1'b1, "busy_lock");
        host_read(2'd0, 4'd0, rd); check("busy_a0_kept", rd, 8'hA5);
        host_read(2'd2, 4'd0, rd); check("busy_c0_or", rd, 8'hBD);

        // reset in the middle of an OR
        check("pre_rst_irq", ap_state_irq, 1'b1);
        cmd = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_irq", ap_state_irq, 1'b0);
        check("abort_dout", data_out, 8'h00);
        host_read(2'd0, 4'd0, rd); check("abort_a0", rd, 8'hA5);
        host_read(2'd1, 4'd0, rd); check("abort_b0", rd, 8'h3C);
        run_op(3'd2, 66, 1'b1, 1'b0, "rerun");
        host_read(2'd2, 4'd0, rd); check("rerun_c0", rd, 8'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ap_bitserial_alu.md
Name: ap_bitserial_alu

Overview:
- Parametrised associative processor with three CAM columns A, B, C of CELL_QUANT words each, WORD_SIZE bits per word.
- Runs a bit-serial, truth-table-driven operation C[r] = op(A[r], B[r]) on all rows in parallel: OR, AND, XOR, and optionally ADD with a per-row carry.
- Adds host load/readback, a start/busy handshake and a sticky completion interrupt.
- Sits between the host register interface and the array; one instance per AP tile.

Parameters:
- WORD_SIZE, 8, bits per cell word (2..32).
- CELL_QUANT, 512, rows per column (any value ≥2, not necessarily a power of 2).
- ADDR_W, $clog2(CELL_QUANT), host address width (derived; do not override).

Ports:
- CLK100MHZ  in  1  sole clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- addr_in  in  ADDR_W  host row address.
- data_in  in  WORD_SIZE  host write data.
- sel_col  in  2  column select: 0=A, 1=B, 2=C, 3=none.
- write_en  in  1  host write strobe.
- read_en  in  1  host read strobe.
- data_out  out  WORD_SIZE  registered host read data.
- start  in  1  single-cycle pulse; launches cmd.
- cmd  in  3  0=OR, 1=AND, 2=XOR, 3=ADD, 4..7 reserved; sampled on start.
- busy  out  1  high while an operation runs.
- ap_state_irq  out  1  sticky done flag.
- irq_clr  in  1  clears ap_state_irq.

Behaviour:
- Reset: data_out=0, busy=0, ap_state_irq=0, FSM=IDLE, bit_cnt=0, pass_cnt=0, carry vector=0.
- rst does not clear array contents. rst mid-operation aborts at once to IDLE; C holds partial results.
- Host write, IDLE only: on write_en, the selected column row addr_in takes data_in at the edge; visible to a read issued the next cycle.
- Host read, IDLE only: on read_en, data_out takes the selected row at the next edge; otherwise data_out holds.
- sel_col=3 or addr_in≥CELL_QUANT: write ignored, read returns 0.
- write_en and read_en together on the same row/column: read returns the old value.
- Host strobes while busy are ignored; data_out holds.
- FSM states: IDLE, COMPARE, WRITE, DONE.
  - IDLE→COMPARE on start with valid cmd; busy rises the cycle after start.
  - Reserved cmd goes IDLE→DONE directly, with no array write.
  - COMPARE: per row, tag = (A[bit]==ka) & (B[bit]==kb) & (ADD only: carry[r]==kc), with (ka,kb,kc) from pass_cnt.
  - WRITE: for tagged rows, C[bit] = LUT result; ADD also sets carry_nxt[r] = LUT carry-out. pass_cnt increments.
  - After the last pass of a bit (4 passes for logic ops, 8 for ADD): ADD copies carry_nxt into carry, bit_cnt increments, pass_cnt=0.
  - WRITE→COMPARE, or WRITE→DONE when bit_cnt reaches WORD_SIZE.
  - DONE: ap_state_irq=1, busy=0, →IDLE.
- Every (a,b[,c]) combination is visited, so every C bit is rewritten (0 or 1). Untagged rows are unchanged in that pass.
- Latency, start to irq: logic ops 2 + 8·WORD_SIZE cycles; ADD 2 + 16·WORD_SIZE cycles.
- ADD: carry cleared at start; sum is WORD_SIZE bits modulo 2^WORD_SIZE; final carry discarded.
- start while busy is ignored.
- irq_clr and DONE in the same cycle: set wins. start does not clear irq.

Optional Feature:
- Macro AP_ADD_EN.
- Defined: cmd=3 performs ADD; carry/carry_nxt vectors and the 8-pass LUT are built.
- Undefined: no carry storage is built; cmd=3 is treated as reserved (direct to DONE, no write).

Decomposition:
- Package ap_pkg: FSM state enum, cmd encodings, op LUT constants (per op: pass count and result/carry-out bits per pass index).
- Sub-module ap_cam_col: one column with host read/write port, masked bit-compare producing a tag vector, and tag-gated single-bit write. Instantiated three times.

Test Plan:
- Load A[0]=0xA5, B[0]=0x3C; start cmd=0 (OR) → irq after 66 cycles (WORD_SIZE=8); read C[0]=0xBD; busy high throughout.
- Same operands, cmd=1 → C[0]=0x24; cmd=2 → C[0]=0x99; rows with no preload keep their reset-independent values, consistent with the op.
- AP_ADD_EN on: A[5]=0xFF, B[5]=0x01, A[6]=0x7F, B[6]=0x7F; cmd=3 → C[5]=0x00, C[6]=0xFE, irq after 130 cycles. AP_ADD_EN off: cmd=3 → irq after 2 cycles, C unchanged.
- cmd=6 → no C change, irq set; irq_clr → irq=0; irq_clr coincident with DONE → irq stays 1.
- During busy: write_en to A[0] and a second start → both ignored; A[0] still 0xA5 after DONE.
- rst asserted mid-OR (cycle 20) → busy=0, irq=0 next cycle; A/B preserved; new start completes correctly.
